// File: rtl/display_scanout.sv
// display_scanout: streams a 64x32 monochrome framebuffer as serial pixels with optional integer upscaling
// Ports: frame_start requests one frame; rd_en/rd_row/rd_data form the synchronous VRAM row-read port
// (data one cycle after rd_en); pix/pix_valid/pix_ready/pix_sof/pix_eol carry the pixel stream;
// busy marks a frame in progress; overrun latches any frame_start seen while busy (cleared by reset).
module display_scanout #(
  parameter int SCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  output logic        rd_en,
  output logic [4:0]  rd_row,
  input  logic [63:0] rd_data,
  output logic        pix,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        busy,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STREAM} state_t;
  localparam logic [2:0] REP_LAST = 3'(SCALE - 1);
  state_t state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [2:0] vrep_q, vrep_d, hrep_q, hrep_d;
  logic [5:0] col_q, col_d;
  logic [63:0] line_q, line_d;
  logic overrun_q, overrun_d;
  logic xfer, h_last, v_last, line_done;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      vrep_q    <= '0;
      hrep_q    <= '0;
      col_q     <= '0;
      line_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      vrep_q    <= vrep_d;
      hrep_q    <= hrep_d;
      col_q     <= col_d;
      line_q    <= line_d;
      overrun_q <= overrun_d;
    end
  end
  always_comb begin
    xfer      = state_q == STREAM && pix_ready;
    h_last    = hrep_q == REP_LAST;
    v_last    = vrep_q == REP_LAST;
    line_done = xfer && h_last && &col_q;
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = frame_start ? FETCH : IDLE;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = STREAM;
      default: state_d = line_done && v_last ? (&row_q ? IDLE : FETCH) : STREAM;
    endcase
  end
  // Vertical repeats re-walk the line buffer without refetching the row
  always_comb begin
    hrep_d    = state_q == IDLE ? '0 : xfer ? (h_last ? '0 : hrep_q + 3'd1) : hrep_q;
    col_d     = state_q == IDLE ? '0 : xfer && h_last ? col_q + 6'd1 : col_q;
    vrep_d    = state_q == IDLE ? '0 : line_done ? (v_last ? '0 : vrep_q + 3'd1) : vrep_q;
    row_d     = state_q == IDLE ? '0 : line_done && v_last ? row_q + 5'd1 : row_q;
    line_d    = state_q == LOAD ? rd_data : line_q;
    overrun_d = overrun_q || (frame_start && state_q != IDLE);
  end
  always_comb begin
    rd_en     = state_q == FETCH;
    rd_row    = rd_en ? row_q : '0;
    pix_valid = state_q == STREAM;
    pix       = pix_valid && line_q[col_q];
    pix_sof   = pix_valid && row_q == '0 && vrep_q == '0 && col_q == '0 && hrep_q == '0;
    pix_eol   = pix_valid && h_last && &col_q;
    busy      = state_q != IDLE;
    overrun   = overrun_q;
  end
endmodule

// File: tb/tb_display_scanout.sv
// tb_display_scanout: scoreboard and vector-table bench for display_scanout at SCALE=1 and SCALE=2
module tb_display_scanout;
  logic clk = 0, rst_n = 0, fs1 = 0, fs2 = 0, rdy1 = 1, rdy2 = 1;
  logic en1, en2, pix1, pix2, pv1, pv2, sof1, sof2, eol1, eol2, busy1, busy2, ovr1, ovr2;
  logic [4:0] row1, row2;
  logic [63:0] rdd1 = '0, rdd2 = '0;
  logic [63:0] vram [32];
  typedef struct packed {logic p, s, e;} px_t;
  typedef struct {int cyc; logic [10:0] o;} vec_t;
  px_t exp1[$], exp2[$];
  px_t held1, held2, last1;
  vec_t tv[12];
  int nvec = 0, nmis = 0, x1 = 0, x2 = 0, r1 = 0, r2 = 0, ones1 = 0;
  bit st1 = 0, st2 = 0;

  display_scanout #(.SCALE(1)) u1 (.clk(clk), .rst_n(rst_n), .frame_start(fs1), .rd_en(en1), .rd_row(row1),
    .rd_data(rdd1), .pix(pix1), .pix_valid(pv1), .pix_ready(rdy1), .pix_sof(sof1), .pix_eol(eol1),
    .busy(busy1), .overrun(ovr1));
  display_scanout #(.SCALE(2)) u2 (.clk(clk), .rst_n(rst_n), .frame_start(fs2), .rd_en(en2), .rd_row(row2),
    .rd_data(rdd2), .pix(pix2), .pix_valid(pv2), .pix_ready(rdy2), .pix_sof(sof2), .pix_eol(eol2),
    .busy(busy2), .overrun(ovr2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en1) rdd1 <= vram[row1];
    if (en2) rdd2 <= vram[row2];
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic fail(input string n);
    nvec++;
    nmis++;
    $display("FAIL %s at %0t", n, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      st1 = 0;
      st2 = 0;
    end else begin
      if (st1) chk("stall_hold1", {pv1, pix1, sof1, eol1}, {1'b1, held1});
      if (pv1 && rdy1) begin
        x1++;
        ones1 += int'(pix1);
        last1 = {pix1, sof1, eol1};
        if (exp1.size() == 0) fail("extra_pix1");
        else chk("pix1", {pix1, sof1, eol1}, exp1.pop_front());
        st1 = 0;
      end else if (pv1) begin
        st1 = 1;
        held1 = {pix1, sof1, eol1};
      end
      if (en1) r1++;
      if (st2) chk("stall_hold2", {pv2, pix2, sof2, eol2}, {1'b1, held2});
      if (pv2 && rdy2) begin
        x2++;
        if (exp2.size() == 0) fail("extra_pix2");
        else chk("pix2", {pix2, sof2, eol2}, exp2.pop_front());
        st2 = 0;
      end else if (pv2) begin
        st2 = 1;
        held2 = {pix2, sof2, eol2};
      end
      if (en2) r2++;
    end
  end

  task automatic push(input int s, input bit which);
    px_t e;
    for (int r = 0; r < 32; r++)
      for (int v = 0; v < s; v++)
        for (int c = 0; c < 64; c++)
          for (int h = 0; h < s; h++) begin
            e = {vram[r][c], r == 0 && v == 0 && c == 0 && h == 0, c == 63 && h == s - 1};
            if (which) exp2.push_back(e);
            else exp1.push_back(e);
          end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("reset1", {en1, row1, pv1, pix1, sof1, eol1, busy1, ovr1}, 0);
    chk("reset2", {en2, row2, pv2, pix2, sof2, eol2, busy2, ovr2}, 0);
  endtask

  // bp: backpressure pattern; tbl: check vector table; rst_at: cycle of a 1-cycle reset (-1 none);
  // fsx: 1 = extra frame_start at cycles 100 and 2112, 2 = only at 2112
  task automatic run1(input bit bp, input bit tbl, input int rst_at, input int fsx);
    int i, n;
    push(1, 0);
    x1 = 0;
    r1 = 0;
    ones1 = 0;
    @(posedge clk); #1 fs1 = 1;
    rdy1 = 1;
    for (i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (tbl)
        foreach (tv[k])
          if (tv[k].cyc == i)
            chk($sformatf("tbl_c%0d", i), {en1, en1 ? row1 : 5'd0, pv1, pix1, sof1, eol1, busy1}, tv[k].o);
      if (i == 1) chk("fetch_row0", {en1, row1}, 6'b1_00000);
      if (fsx == 1 && i == 100) chk("ovr_pre", ovr1, 0);
      if (fsx == 1 && i == 101) chk("ovr_post", ovr1, 1);
      if (i > 1 && !busy1) break;
      @(posedge clk); #1;
      n = i + 1;
      fs1 = (fsx == 1 && n == 100) || (fsx >= 1 && n == 2112);
      rdy1 = !bp ? 1'b1 : n < 20 ? 1'b1 : n < 25 ? 1'b0 : 1'($urandom_range(0, 1));
      rst_n = n != rst_at;
    end
    fs1 = 0;
    rdy1 = 1;
    if (i == 20000) fail("timeout1");
    if (rst_at < 0) begin
      if (!bp) chk("frame_len1", i, 2113);
      chk("xfers1", x1, 2048);
      chk("rden1", r1, 32);
      chk("sb1_left", exp1.size(), 0);
    end else exp1.delete();
  endtask

  task automatic run2();
    int i, gaps;
    gaps = 0;
    push(2, 1);
    x2 = 0;
    r2 = 0;
    @(posedge clk); #1 fs2 = 1;
    for (i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (i >= 3 && i <= 258 && !pv2) gaps++;
      if (i > 1 && !busy2) break;
      @(posedge clk); #1 fs2 = 0;
    end
    if (i == 20000) fail("timeout2");
    chk("frame_len2", i, 8257);
    chk("line01_gaps", gaps, 0);
    chk("xfers2", x2, 8192);
    chk("rden2", r2, 32);
    chk("sb2_left", exp2.size(), 0);
  endtask

  initial begin
    // o = {rd_en, rd_row, pix_valid, pix, pix_sof, pix_eol, busy}
    tv = '{'{0, 11'b0_00000_00000}, '{1, 11'b1_00000_00001}, '{2, 11'b0_00000_00001},
           '{3, 11'b0_00000_11101}, '{4, 11'b0_00000_10001}, '{66, 11'b0_00000_10011},
           '{67, 11'b1_00001_00001}, '{68, 11'b0_00000_00001}, '{69, 11'b0_00000_10001},
           '{2047, 11'b1_11111_00001}, '{2112, 11'b0_00000_10011}, '{2113, 11'b0_00000_00000}};
    foreach (vram[r]) vram[r] = '0;
    do_reset();
    vram[0] = 64'h1;
    run1(0, 1, -1, 0);
    foreach (vram[r]) vram[r] = {$urandom, $urandom};
    run1(1, 0, -1, 0);
    foreach (vram[r]) vram[r] = '0;
    vram[31] = 64'h8000_0000_0000_0000;
    run1(0, 0, -1, 2);
    chk("last_pix", last1, 3'b101);
    chk("ones", ones1, 1);
    chk("ovr_final_xfer", ovr1, 1);
    do_reset();
    vram[0] = 64'h5;
    run1(0, 0, -1, 1);
    chk("ovr_ignored", ovr1, 1);
    run1(0, 0, -1, 0);
    chk("ovr_sticky", ovr1, 1);
    run1(0, 0, 680, 0);
    chk("rst_mid", {en1, row1, pv1, pix1, sof1, eol1, busy1, ovr1}, 0);
    run1(0, 0, -1, 0);
    foreach (vram[r]) vram[r] = '0;
    vram[0] = 64'h2;
    run2();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
